wb_stage_nway: RTL and testbench
================================

WB_STAGE_NWAY -- requirements
Module: wb_stage_nway

Interface
REQ-001 Parameter ISSUE_W, default 2: number of issue slots (1..4); slot 0 is the oldest instruction.
REQ-002 Parameter TRACE_SERIAL, default 1: 1 = one debug-trace entry per writing slot, one entry per cycle; 0 = slot-0-only trace, no stall.
REQ-003 Slot record SLOT_WD = 71 bits: {valid[70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}. Slot i occupies bus bits [i*71 +: 71].
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ws_allowin  output  1  WB can accept a group this cycle.
REQ-007 ms_to_ws_valid  input  1  MEM presents a valid group.
REQ-008 ms_to_ws_bus  input  ISSUE_W*71  MEM group, slot-packed.
REQ-009 ws_to_rf_bus  output  ISSUE_W*38  per-slot {we, waddr[4:0], wdata[31:0]}; slot i at [i*38 +: 38].
REQ-010 ws_forward_bus  output  1+ISSUE_W*38  {ws_valid, per-slot {gr_we&valid, dest, result}}; slot i at [i*38 +: 38].
REQ-011 debug_wb_pc  output  32  traced instruction PC.
REQ-012 debug_wb_rf_wen  output  4  traced write enable, replicated across 4 bits.
REQ-013 debug_wb_rf_wnum  output  5  traced destination register.
REQ-014 debug_wb_rf_wdata  output  32  traced write data.

Function
REQ-015 Write enable for slot i: w[i] = ws_valid & valid[i] & gr_we[i]; the slot-0 valid bit is honoured, not forced.
REQ-016 Capture: if ms_to_ws_valid & ws_allowin, the group is latched at the clock edge. ws_valid <= ms_to_ws_valid whenever ws_allowin = 1.
REQ-017 ws_allowin = ~ws_valid | ws_ready_go. A group with no writing slot is retired in one cycle.
REQ-018 Pending mask: at capture, pend <= {valid[i]&gr_we[i]}. Each trace cycle clears the lowest set bit of pend.
REQ-019 TRACE_SERIAL=1: ws_ready_go = (popcount(pend) <= 1). A group with k >= 1 writes stays in WB for exactly k cycles.
REQ-020 TRACE_SERIAL=1 trace: entry = lowest set bit of pend. If pend = 0, trace slot 0 with wen = 0.
REQ-021 TRACE_SERIAL=0: ws_ready_go = 1. Trace is slot 0 with wen = {4{w[0]}}.
REQ-022 RF write ports assert only in the retire cycle (ws_valid & ws_ready_go), so each write occurs exactly once.
REQ-023 Same-destination rule: if w[i] & w[j], j > i, and dest[i] == dest[j], slot i's RF we is 0 and the youngest slot wins.
REQ-024 The same-destination rule does not suppress trace entries; every writing slot is traced in slot order.
REQ-025 Writes to dest 0 pass through unchanged; the register file ignores r0.
REQ-026 The forward bus is valid for every cycle of ws_valid, including serialization stall cycles.
REQ-027 The forward bus does not apply same-destination suppression; the consumer resolves priority by slot order.

Reset
REQ-028 Reset clears ws_valid and pend. All RF we and debug wen are 0 in the cycle after reset, and ws_allowin = 1.
REQ-029 Reset asserted mid-serialization aborts the group: no further trace entries and no RF write for that group.
REQ-030 Bus registers are not reset; outputs are gated by ws_valid.

Structure
REQ-031 The shared package holds SLOT_WD, RF_PORT_WD (38), and the slot field offset constants.
REQ-032 Sub-module wb_trace_pick is a combinational lowest-set-bit priority picker over pend, outputting a one-hot pick and an index; it is instantiated once.
REQ-033 Target size is 150–300 lines; the per-slot logic is built with generate loops.

Verification
REQ-034 ISSUE_W=2, TRACE_SERIAL=1, slot0 {we, r3, 0x11, pc 0xBFC00000}, slot1 {we, r4, 0x22, pc 0xBFC00004}:
- trace is pc ...00/r3/0x11, then pc ...04/r4/0x22 on consecutive cycles;
- ws_allowin is low in cycle 1;
- both RF writes occur in cycle 2.
REQ-035 Same dest r5 with values 0xA (slot 0) and 0xB (slot 1): RF shows slot-0 we = 0 and slot-1 writes 0xB; trace shows 0xA then 0xB.
REQ-036 Group with no writes, pc 0x80000000: one cycle, wen = 0, debug_wb_pc = 0x80000000, ws_allowin stays 1.
REQ-037 ISSUE_W=4, slots 1 and 3 writing, back-to-back groups: trace spans exactly 2 cycles per group and no group is lost or duplicated.
REQ-038 Reset in the first cycle of a 2-write group: next cycle has wen = 0, all RF we = 0, and ws_valid = 0.
REQ-039 TRACE_SERIAL=0 with a 2-write group: retires in 1 cycle, both RF ports write, and the trace shows slot 0 only.

Source files
------------

// File: rtl/wb_stage_nway_pkg.sv
// Shared widths and field offsets for the n-way write-back stage.
package wb_stage_nway_pkg;

  localparam int SLOT_WD    = 71;
  localparam int RF_PORT_WD = 38;

  // Field offsets inside one slot record.
  localparam int SLOT_PC_LSB     = 0;
  localparam int SLOT_RESULT_LSB = 32;
  localparam int SLOT_DEST_LSB   = 64;
  localparam int SLOT_GR_WE_BIT  = 69;
  localparam int SLOT_VALID_BIT  = 70;

  typedef struct packed {
    logic        valid;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } slot_t;

  function automatic logic [RF_PORT_WD-1:0] pack_rf_port(input logic        we,
                                                         input logic [4:0]  addr,
                                                         input logic [31:0] data);
    return {we, addr, data};
  endfunction

endpackage

// File: rtl/wb_trace_pick.sv
// Lowest-set-bit priority picker over the pending-trace mask.
module wb_trace_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_pend,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Isolate the lowest set bit; index defaults to 0 when nothing is pending.
  always_comb begin
    o_onehot = i_pend & (~i_pend + 1'b1);
    o_any    = |i_pend;
    o_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_pend[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/wb_stage_nway.sv
// N-way write-back stage: register-file writes, forwarding and serialized debug trace.
module wb_stage_nway
  import wb_stage_nway_pkg::*;
#(
  parameter int ISSUE_W      = 2,
  parameter int TRACE_SERIAL = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          ws_allowin,
  input  logic                          ms_to_ws_valid,
  input  logic [ISSUE_W*SLOT_WD-1:0]    ms_to_ws_bus,
  output logic [ISSUE_W*RF_PORT_WD-1:0] ws_to_rf_bus,
  output logic [ISSUE_W*RF_PORT_WD:0]   ws_forward_bus,
  output logic [31:0]                   debug_wb_pc,
  output logic [3:0]                    debug_wb_rf_wen,
  output logic [4:0]                    debug_wb_rf_wnum,
  output logic [31:0]                   debug_wb_rf_wdata
);

  localparam int IDX_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;

  logic                       r_ws_valid;
  logic [ISSUE_W-1:0]         r_pend;
  logic [ISSUE_W*SLOT_WD-1:0] r_bus;

  slot_t              w_slot [ISSUE_W];
  logic [ISSUE_W-1:0] w_we;
  logic [ISSUE_W-1:0] w_cap_mask;
  logic [ISSUE_W-1:0] w_rf_we;
  logic [ISSUE_W-1:0] w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_ready_go;
  logic               w_retire;
  slot_t              w_trace_slot;
  logic               w_trace_wen;

  wb_trace_pick #(
    .N    (ISSUE_W),
    .IDX_W(IDX_W)
  ) u_pick (
    .i_pend  (r_pend),
    .o_onehot(w_pick_onehot),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_slot
    logic w_shadowed;

    assign w_slot[g] = '{
      valid:  r_bus[g*SLOT_WD + SLOT_VALID_BIT],
      gr_we:  r_bus[g*SLOT_WD + SLOT_GR_WE_BIT],
      dest:   r_bus[g*SLOT_WD + SLOT_DEST_LSB +: 5],
      result: r_bus[g*SLOT_WD + SLOT_RESULT_LSB +: 32],
      pc:     r_bus[g*SLOT_WD + SLOT_PC_LSB +: 32]
    };

    assign w_cap_mask[g] = ms_to_ws_bus[g*SLOT_WD + SLOT_VALID_BIT] &
                           ms_to_ws_bus[g*SLOT_WD + SLOT_GR_WE_BIT];
    assign w_we[g] = r_ws_valid & w_slot[g].valid & w_slot[g].gr_we;

    // A younger writer to the same register hides this slot's RF write.
    always_comb begin
      w_shadowed = 1'b0;
      for (int j = g + 1; j < ISSUE_W; j++) begin
        if (w_we[j] && (w_slot[j].dest == w_slot[g].dest)) w_shadowed = 1'b1;
      end
    end

    assign w_rf_we[g] = w_we[g] & w_retire & ~w_shadowed;
    assign ws_to_rf_bus[g*RF_PORT_WD +: RF_PORT_WD] =
      pack_rf_port(w_rf_we[g], w_slot[g].dest, w_slot[g].result);
    // Forwarding keeps every writer; the consumer resolves slot priority.
    assign ws_forward_bus[g*RF_PORT_WD +: RF_PORT_WD] =
      pack_rf_port(w_we[g], w_slot[g].dest, w_slot[g].result);
  end

  assign ws_forward_bus[ISSUE_W*RF_PORT_WD] = r_ws_valid;

  // Serial trace holds the group until at most one pending entry remains.
  always_comb begin
    w_ready_go = 1'b1;
    if (TRACE_SERIAL != 0) w_ready_go = ((r_pend & (r_pend - 1'b1)) == '0);
  end

  assign w_retire   = r_ws_valid & w_ready_go;
  assign ws_allowin = ~r_ws_valid | w_ready_go;

  // Select the traced slot: lowest pending writer, or slot 0 when unserialized.
  always_comb begin
    w_trace_slot = w_slot[0];
    w_trace_wen  = w_we[0];
    if (TRACE_SERIAL != 0) begin
      w_trace_slot = w_slot[w_pick_idx];
      w_trace_wen  = r_ws_valid & w_pick_any;
    end
  end

  assign debug_wb_pc       = w_trace_slot.pc;
  assign debug_wb_rf_wen   = {4{w_trace_wen}};
  assign debug_wb_rf_wnum  = w_trace_slot.dest;
  assign debug_wb_rf_wdata = w_trace_slot.result;

  // Group valid and pending-trace mask; reset aborts any in-flight group.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws_valid <= 1'b0;
      r_pend     <= '0;
    end else if (ws_allowin) begin
      r_ws_valid <= ms_to_ws_valid;
      r_pend     <= ms_to_ws_valid ? w_cap_mask : '0;
    end else begin
      r_pend <= r_pend & ~w_pick_onehot;
    end
  end

  // Group payload; left unreset because every output is gated by r_ws_valid.
  always_ff @(posedge clk) begin
    if (ws_allowin && ms_to_ws_valid) r_bus <= ms_to_ws_bus;
  end

endmodule

// File: tb/tb_wb_stage_nway.sv
// Directed bench: 2-way serial (table), 4-way serial and 2-way unserialized sequences.
module tb_wb_stage_nway;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DUT A: ISSUE_W=2, TRACE_SERIAL=1
  logic         a_vld, a_allowin;
  logic [141:0] a_bus;
  logic [75:0]  a_rf;
  logic [76:0]  a_fwd;
  logic [31:0]  a_pc, a_wdata;
  logic [3:0]   a_wen;
  logic [4:0]   a_wnum;

  // DUT B: ISSUE_W=4, TRACE_SERIAL=1
  logic         b_vld, b_allowin;
  logic [283:0] b_bus;
  logic [151:0] b_rf;
  logic [152:0] b_fwd;
  logic [31:0]  b_pc, b_wdata;
  logic [3:0]   b_wen;
  logic [4:0]   b_wnum;

  // DUT C: ISSUE_W=2, TRACE_SERIAL=0
  logic         c_vld, c_allowin;
  logic [141:0] c_bus;
  logic [75:0]  c_rf;
  logic [76:0]  c_fwd;
  logic [31:0]  c_pc, c_wdata;
  logic [3:0]   c_wen;
  logic [4:0]   c_wnum;

  wb_stage_nway #(.ISSUE_W(2), .TRACE_SERIAL(1)) u_a (
    .clk(clk), .reset(reset), .ws_allowin(a_allowin), .ms_to_ws_valid(a_vld),
    .ms_to_ws_bus(a_bus), .ws_to_rf_bus(a_rf), .ws_forward_bus(a_fwd),
    .debug_wb_pc(a_pc), .debug_wb_rf_wen(a_wen), .debug_wb_rf_wnum(a_wnum),
    .debug_wb_rf_wdata(a_wdata)
  );

  wb_stage_nway #(.ISSUE_W(4), .TRACE_SERIAL(1)) u_b (
    .clk(clk), .reset(reset), .ws_allowin(b_allowin), .ms_to_ws_valid(b_vld),
    .ms_to_ws_bus(b_bus), .ws_to_rf_bus(b_rf), .ws_forward_bus(b_fwd),
    .debug_wb_pc(b_pc), .debug_wb_rf_wen(b_wen), .debug_wb_rf_wnum(b_wnum),
    .debug_wb_rf_wdata(b_wdata)
  );

  wb_stage_nway #(.ISSUE_W(2), .TRACE_SERIAL(0)) u_c (
    .clk(clk), .reset(reset), .ws_allowin(c_allowin), .ms_to_ws_valid(c_vld),
    .ms_to_ws_bus(c_bus), .ws_to_rf_bus(c_rf), .ws_forward_bus(c_fwd),
    .debug_wb_pc(c_pc), .debug_wb_rf_wen(c_wen), .debug_wb_rf_wnum(c_wnum),
    .debug_wb_rf_wdata(c_wdata)
  );

  function automatic logic [70:0] mk_slot(input logic v, input logic we, input logic [4:0] d,
                                          input logic [31:0] res, input logic [31:0] pc);
    return {v, we, d, res, pc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rst;
    logic         vld;
    logic [141:0] bus;
    logic         chk_pc;
    logic         exp_allowin;
    logic [3:0]   exp_wen;
    logic [31:0]  exp_pc;
    logic [4:0]   exp_wnum;
    logic [31:0]  exp_wdata;
    logic [1:0]   exp_rf_we;
    logic [31:0]  exp_rf1_data;
    logic [2:0]   exp_fwd;  // {ws_valid, fwd we slot1, fwd we slot0}
  } vec_t;

  function automatic vec_t mkv(input logic rst, input logic vld, input logic [141:0] bus,
                               input logic chk_pc, input logic alw, input logic [3:0] wen,
                               input logic [31:0] pc, input logic [4:0] wnum,
                               input logic [31:0] wdata, input logic [1:0] rf_we,
                               input logic [31:0] rf1, input logic [2:0] fwd);
    vec_t v;
    v.rst = rst; v.vld = vld; v.bus = bus; v.chk_pc = chk_pc; v.exp_allowin = alw;
    v.exp_wen = wen; v.exp_pc = pc; v.exp_wnum = wnum; v.exp_wdata = wdata;
    v.exp_rf_we = rf_we; v.exp_rf1_data = rf1; v.exp_fwd = fwd;
    return v;
  endfunction

  vec_t tab [12];
  logic [141:0] g1, g2, g3, g4;
  logic [283:0] x1, x2;

  initial begin
    g1 = {mk_slot(1, 1, 5'd4, 32'h22, 32'hBFC0_0004), mk_slot(1, 1, 5'd3, 32'h11, 32'hBFC0_0000)};
    g2 = {mk_slot(1, 1, 5'd5, 32'hB, 32'h104), mk_slot(1, 1, 5'd5, 32'hA, 32'h100)};
    g3 = {mk_slot(0, 0, 5'd0, 32'h0, 32'h0), mk_slot(1, 0, 5'd9, 32'h99, 32'h8000_0000)};
    g4 = {mk_slot(1, 1, 5'd7, 32'h77, 32'h204), mk_slot(0, 1, 5'd6, 32'h66, 32'h200)};
    x1 = {mk_slot(1, 1, 5'd3, 32'h103, 32'h100C), mk_slot(1, 0, 5'd0, 32'h0, 32'h1008),
          mk_slot(1, 1, 5'd1, 32'h101, 32'h1004), mk_slot(1, 0, 5'd0, 32'h0, 32'h1000)};
    x2 = {mk_slot(1, 1, 5'd11, 32'h203, 32'h200C), mk_slot(1, 0, 5'd0, 32'h0, 32'h2008),
          mk_slot(1, 1, 5'd9, 32'h201, 32'h2004), mk_slot(1, 0, 5'd0, 32'h0, 32'h2000)};

    //            rst vld bus pc alw wen   pc             wnum wdata   rfwe  rf1    fwd
    tab[0]  = mkv(0, 1, g1, 0, 1, 4'h0, 32'h0,         0, 32'h0,  2'b00, 32'h0,  3'b000);
    tab[1]  = mkv(0, 0, g1, 1, 0, 4'hF, 32'hBFC0_0000, 3, 32'h11, 2'b00, 32'h0,  3'b111);
    tab[2]  = mkv(0, 1, g2, 1, 1, 4'hF, 32'hBFC0_0004, 4, 32'h22, 2'b11, 32'h22, 3'b111);
    tab[3]  = mkv(0, 0, g2, 1, 0, 4'hF, 32'h100,       5, 32'hA,  2'b00, 32'h0,  3'b111);
    tab[4]  = mkv(0, 1, g3, 1, 1, 4'hF, 32'h104,       5, 32'hB,  2'b10, 32'hB,  3'b111);
    tab[5]  = mkv(0, 0, g3, 1, 1, 4'h0, 32'h8000_0000, 0, 32'h0,  2'b00, 32'h0,  3'b100);
    tab[6]  = mkv(0, 1, g1, 0, 1, 4'h0, 32'h0,         0, 32'h0,  2'b00, 32'h0,  3'b000);
    tab[7]  = mkv(1, 0, g1, 1, 0, 4'hF, 32'hBFC0_0000, 3, 32'h11, 2'b00, 32'h0,  3'b111);
    tab[8]  = mkv(0, 0, g1, 0, 1, 4'h0, 32'h0,         0, 32'h0,  2'b00, 32'h0,  3'b000);
    tab[9]  = mkv(0, 1, g4, 0, 1, 4'h0, 32'h0,         0, 32'h0,  2'b00, 32'h0,  3'b000);
    tab[10] = mkv(0, 0, g4, 1, 1, 4'hF, 32'h204,       7, 32'h77, 2'b10, 32'h77, 3'b110);
    tab[11] = mkv(0, 0, g4, 0, 1, 4'h0, 32'h0,         0, 32'h0,  2'b00, 32'h0,  3'b000);

    reset = 1'b1;
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
    a_bus = '0;   b_bus = '0;   c_bus = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 2-way serialized trace, driven from the vector table
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("a v%0d allowin", k), 32'(a_allowin), 32'(tab[k].exp_allowin));
      chk($sformatf("a v%0d wen", k), 32'(a_wen), 32'(tab[k].exp_wen));
      if (tab[k].chk_pc) chk($sformatf("a v%0d pc", k), a_pc, tab[k].exp_pc);
      if (tab[k].exp_wen != 4'h0) begin
        chk($sformatf("a v%0d wnum", k), 32'(a_wnum), 32'(tab[k].exp_wnum));
        chk($sformatf("a v%0d wdata", k), a_wdata, tab[k].exp_wdata);
      end
      chk($sformatf("a v%0d rf_we", k), 32'({a_rf[75], a_rf[37]}), 32'(tab[k].exp_rf_we));
      if (tab[k].exp_rf_we[1])
        chk($sformatf("a v%0d rf1_data", k), a_rf[38 +: 32], tab[k].exp_rf1_data);
      chk($sformatf("a v%0d fwd", k), 32'({a_fwd[76], a_fwd[75], a_fwd[37]}),
          32'(tab[k].exp_fwd));
      reset = tab[k].rst;
      a_vld = tab[k].vld;
      a_bus = tab[k].bus;
    end

    // 4-way, slots 1 and 3 writing, two groups back to back
    @(negedge clk);
    b_vld = 1'b1; b_bus = x1;
    @(negedge clk);
    chk("b n1 allowin", 32'(b_allowin), 32'd0);
    chk("b n1 wen", 32'(b_wen), 32'hF);
    chk("b n1 pc", b_pc, 32'h1004);
    chk("b n1 rf_we", 32'({b_rf[151], b_rf[113], b_rf[75], b_rf[37]}), 32'h0);
    b_bus = x2;
    @(negedge clk);
    chk("b n2 allowin", 32'(b_allowin), 32'd1);
    chk("b n2 pc", b_pc, 32'h100C);
    chk("b n2 wdata", b_wdata, 32'h103);
    chk("b n2 rf_we", 32'({b_rf[151], b_rf[113], b_rf[75], b_rf[37]}), 32'hA);
    chk("b n2 rf3_data", b_rf[114 +: 32], 32'h103);
    @(negedge clk);
    chk("b n3 allowin", 32'(b_allowin), 32'd0);
    chk("b n3 pc", b_pc, 32'h2004);
    chk("b n3 wnum", 32'(b_wnum), 32'd9);
    chk("b n3 fwd_valid", 32'(b_fwd[152]), 32'd1);
    b_vld = 1'b0;
    @(negedge clk);
    chk("b n4 allowin", 32'(b_allowin), 32'd1);
    chk("b n4 pc", b_pc, 32'h200C);
    chk("b n4 rf_we", 32'({b_rf[151], b_rf[113], b_rf[75], b_rf[37]}), 32'hA);
    @(negedge clk);
    chk("b n5 wen", 32'(b_wen), 32'h0);
    chk("b n5 fwd_valid", 32'(b_fwd[152]), 32'd0);

    // Unserialized trace: two writes retire in one cycle, only slot 0 traced
    c_vld = 1'b1; c_bus = g1;
    @(negedge clk);
    chk("c n1 allowin", 32'(c_allowin), 32'd1);
    chk("c n1 wen", 32'(c_wen), 32'hF);
    chk("c n1 pc", c_pc, 32'hBFC0_0000);
    chk("c n1 wnum", 32'(c_wnum), 32'd3);
    chk("c n1 rf_we", 32'({c_rf[75], c_rf[37]}), 32'h3);
    chk("c n1 rf1_data", c_rf[38 +: 32], 32'h22);
    c_bus = g4;
    @(negedge clk);
    chk("c n2 wen", 32'(c_wen), 32'h0);
    chk("c n2 pc", c_pc, 32'h200);
    chk("c n2 rf_we", 32'({c_rf[75], c_rf[37]}), 32'h2);
    c_vld = 1'b0;
    @(negedge clk);
    chk("c n3 fwd_valid", 32'(c_fwd[76]), 32'd0);
    chk("c n3 rf_we", 32'({c_rf[75], c_rf[37]}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
